// File: rtl/bus_pkg.sv
// Shared types, constants and default widths for the bit-serial system bus.
package bus_pkg;

   localparam int unsigned DEF_ADDR_WIDTH     = 12;
   localparam int unsigned DEF_DATA_WIDTH     = 8;
   localparam int unsigned DEF_MEM_ADDR_WIDTH = 12;
   localparam int unsigned DEF_TIMEOUT        = 64;

   localparam logic MODE_READ  = 1'b0;
   localparam logic MODE_WRITE = 1'b1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      WDATA = 3'd2,
      WRITE = 3'd3,
      FETCH = 3'd4,
      RDATA = 3'd5
   } slave_state_t;

   // Larger of two widths, used to size shared counters.
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/slave_bram.sv
// Single-port local RAM: synchronous write, registered read (1-cycle latency).
module slave_bram
   import bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Array carries no reset so it maps onto block RAM and survives bus resets.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/bus_slave_port.sv
// Responder end of the bit-serial bus: serial address/mode/data in, RAM access,
// serial read data out, with an idle timeout that aborts stuck transactions.
module bus_slave_port
   import bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int unsigned MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
   parameter int unsigned TIMEOUT        = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic master_valid,
   input  logic master_tx_data,
   input  logic mode,
   output logic slave_ready,
   output logic slave_valid,
   output logic slave_tx_data,
   input  logic master_ready,
   output logic done,
   output logic error,
   output logic busy
);

   localparam int unsigned MAX_W = max_u(ADDR_WIDTH, DATA_WIDTH);
   localparam int unsigned CNT_W = $clog2(MAX_W + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT);

   slave_state_t              state_q, state_d;
   logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
   logic [TMO_W-1:0]          tmo_q, tmo_d;
   logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]     data_q, data_d;
   logic                      mode_q, mode_d;
   logic                      fetch_q, fetch_d;
   logic                      done_q, done_d;
   logic                      error_q, error_d;

   logic                      mem_we_c;
   logic [DATA_WIDTH-1:0]     mem_rdata;
   logic                      hs_in_c;
   logic                      hs_out_c;
   logic                      tmo_expired_c;
   logic [MEM_ADDR_WIDTH-1:0] addr_shift_c;
   logic [DATA_WIDTH-1:0]     data_shift_c;

   // Handshake strobes and port outputs decoded from the registered state.
   assign slave_ready   = !rst && (state_q inside {IDLE, ADDR, WDATA});
   assign slave_valid   = (state_q == RDATA);
   assign slave_tx_data = slave_valid && data_q[0];
   assign busy          = (state_q != IDLE);
   assign done          = done_q;
   assign error         = error_q;

   assign hs_in_c       = master_valid && slave_ready;
   assign hs_out_c      = slave_valid && master_ready;
   assign tmo_expired_c = (tmo_q == TMO_W'(TIMEOUT - 1));

   // LSB-first shift-in: new bit enters at the top, earlier bits move down.
   assign addr_shift_c = (addr_q >> 1) | (MEM_ADDR_WIDTH'(master_tx_data) << (MEM_ADDR_WIDTH - 1));
   assign data_shift_c = (data_q >> 1) | (DATA_WIDTH'(master_tx_data) << (DATA_WIDTH - 1));

   // Local storage; read address is held in addr_q throughout FETCH.
   slave_bram #(
      .ADDR_WIDTH (MEM_ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_bram (
      .clk   (clk),
      .we    (mem_we_c),
      .addr  (addr_q),
      .wdata (data_q),
      .rdata (mem_rdata)
   );

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         tmo_q     <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         mode_q    <= 1'b0;
         fetch_q   <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         tmo_q     <= tmo_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         mode_q    <= mode_d;
         fetch_q   <= fetch_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   // Next-state, counters, shift registers and pulse generation.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      tmo_d     = tmo_q;
      addr_d    = addr_q;
      data_d    = data_q;
      mode_d    = mode_q;
      fetch_d   = fetch_q;
      done_d    = 1'b0;
      error_d   = 1'b0;
      mem_we_c  = 1'b0;

      unique case (state_q)
         IDLE: begin
            tmo_d = '0;
            if (hs_in_c) begin
               addr_d = addr_shift_c;
               mode_d = mode;
               if (ADDR_WIDTH == 1) begin
                  bit_cnt_d = '0;
                  state_d   = (mode == MODE_WRITE) ? WDATA : FETCH;
               end else begin
                  bit_cnt_d = CNT_W'(1);
                  state_d   = ADDR;
               end
            end
         end

         ADDR: begin
            if (hs_in_c) begin
               tmo_d = '0;
               // Bits above the local memory width are dropped.
               if (bit_cnt_q < CNT_W'(MEM_ADDR_WIDTH)) begin
                  addr_d = addr_shift_c;
               end
               if (bit_cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = (mode_q == MODE_WRITE) ? WDATA : FETCH;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else if (tmo_expired_c) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
               tmo_d     = '0;
               error_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         WDATA: begin
            if (hs_in_c) begin
               tmo_d  = '0;
               data_d = data_shift_c;
               if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = WRITE;
                  done_d    = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else if (tmo_expired_c) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
               tmo_d     = '0;
               error_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         WRITE: begin
            // done is already high this cycle (registered on the last data bit).
            mem_we_c = 1'b1;
            tmo_d    = '0;
            state_d  = IDLE;
         end

         FETCH: begin
            // First cycle lets the RAM register its output, second loads it.
            tmo_d = '0;
            if (!fetch_q) begin
               fetch_d = 1'b1;
            end else begin
               fetch_d = 1'b0;
               data_d  = mem_rdata;
               state_d = RDATA;
            end
         end

         RDATA: begin
            if (hs_out_c) begin
               tmo_d  = '0;
               data_d = data_q >> 1;
               if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = IDLE;
                  done_d    = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else if (tmo_expired_c) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
               tmo_d     = '0;
               error_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         default: begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            tmo_d     = '0;
            fetch_d   = 1'b0;
         end
      endcase
   end

endmodule
